// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for prog_loader.
// slave is the loader side; master is the byte source / memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a count-prefixed byte stream into instruction memory as 16-bit words, holding the CPU in reset.
// Define PROG_LOADER_CSUM_EN to expect and verify a trailing 8-bit checksum byte.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  prog_loader_if.slave bus,
  output logic         cpu_reset_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  // One extra counter bit so a 256-word load can be counted without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    WRITE,
`ifdef PROG_LOADER_CSUM_EN
    CSUM,
`endif
    FIN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              xfer;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
`endif

  assign xfer = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= csum_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    count_d      = count_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_reset_d  = cpu_reset_q;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    csum_d       = csum_q;
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = COUNT;
          cnt_d       = '0;
          cpu_reset_d = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
          csum_d      = '0;
          err_d       = 1'b0;
`endif
        end
      end
      COUNT: begin
        bus.in_ready = 1'b1;
        if (xfer) begin
          // A count byte of zero stands for the full 256 words.
          count_d = (bus.in_data == 8'd0) ? CNT_W'(256) : CNT_W'(bus.in_data);
          state_d = HI;
        end
      end
      HI: begin
        bus.in_ready = 1'b1;
        if (xfer) begin
          wdata_d[15:8] = bus.in_data;
`ifdef PROG_LOADER_CSUM_EN
          csum_d        = csum_q + bus.in_data;
`endif
          state_d       = LO;
        end
      end
      LO: begin
        bus.in_ready = 1'b1;
        if (xfer) begin
          wdata_d[7:0] = bus.in_data;
          addr_d       = cnt_q[ADDR_W-1:0];
`ifdef PROG_LOADER_CSUM_EN
          csum_d       = csum_q + bus.in_data;
`endif
          state_d      = WRITE;
        end
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if ((cnt_q + CNT_W'(1)) == count_q) begin
`ifdef PROG_LOADER_CSUM_EN
          state_d     = CSUM;
`else
          state_d     = FIN;
          cpu_reset_d = 1'b0;
`endif
        end else begin
          state_d = HI;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      CSUM: begin
        bus.in_ready = 1'b1;
        if (xfer) begin
          if (bus.in_data == csum_q) begin
            state_d     = FIN;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_reset_o   = cpu_reset_q;
  assign busy_o        = (state_q != IDLE) && (state_q != FIN);
  assign done_o        = (state_q == FIN);
`ifdef PROG_LOADER_CSUM_EN
  assign err_o         = err_q;
`else
  assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a stream-level reference model.
// Honours PROG_LOADER_CSUM_EN to exercise the checksum byte and error path.
module tb_prog_loader;

  logic clk = 1'b0;
  logic reset;
  logic startPulse;
  logic cpuReset;
  logic busy;
  logic done;
  logic err;

  prog_loader_if #(.ADDR_W(8), .DATA_W(16)) busIf ();

  prog_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (startPulse),
    .bus         (busIf),
    .cpu_reset_o (cpuReset),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  int startCycle = 0;
  int doneCycle  = 0;
  int doneCount  = 0;
  logic prevWe   = 1'b0;
  logic [7:0]  streamQ[$];
  logic [31:0] addrQ[$];
  logic [31:0] dataQ[$];
  int streamLimit;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Capture every memory write and watch the per-write handshake rules.
  always @(negedge clk) begin
    if (reset) begin
      prevWe = 1'b0;
    end else begin
      if (busIf.mem_we) begin
        addrQ.push_back(32'(busIf.mem_addr));
        dataQ.push_back(32'(busIf.mem_wdata));
        checkOutput("readyInWrite", 32'(busIf.in_ready), 32'd0);
        checkOutput("weOneCycle", 32'(prevWe), 32'd0);
      end
      if (done) begin
        doneCount++;
        doneCycle = cycleCount;
      end
      prevWe = busIf.mem_we;
    end
  end

  // Count byte, 2N data bytes, and a checksum byte when that feature is built in.
  task automatic makeStream(input int n, input bit badCsum);
    logic [7:0] b;
    logic [7:0] sum;
    streamQ.delete();
    sum = 8'd0;
    streamQ.push_back((n == 256) ? 8'd0 : 8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      sum = sum + b;
      streamQ.push_back(b);
    end
`ifdef PROG_LOADER_CSUM_EN
    streamQ.push_back(badCsum ? sum + 8'd1 : sum);
`else
    if (badCsum) sum = 8'd0;
`endif
  endtask

  task automatic beginLoad();
    addrQ.delete();
    dataQ.delete();
    doneCount = 0;
    startPulse = 1'b1;
    @(negedge clk);
    startPulse = 1'b0;
    startCycle = cycleCount;
  endtask

  // mode 0: valid always high; 1: valid toggles; 2: random valid plus stray start pulses.
  task automatic applyStimulus(input int mode);
    int idx = 0;
    int guard = 0;
    logic v;
    logic toggle = 1'b1;
    logic acc;
    while (idx < streamLimit && guard < 4000) begin
      case (mode)
        0: v = 1'b1;
        1: begin v = toggle; toggle = ~toggle; end
        default: v = 1'($urandom);
      endcase
      busIf.in_valid = v;
      busIf.in_data  = v ? streamQ[idx] : 8'($urandom);
      startPulse     = (mode == 2) && ($urandom_range(0, 7) == 0);
      acc = v && busIf.in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      guard++;
    end
    busIf.in_valid = 1'b0;
    startPulse     = 1'b0;
    if (idx < streamLimit) checkOutput("streamTimeout", 32'(idx), 32'(streamLimit));
  endtask

  task automatic finishLoad(input int mode);
    int n;
    int guard = 0;
    logic [7:0] sum;
    logic expectOk;
    logic [15:0] word;
    n = (streamQ[0] == 8'd0) ? 256 : int'(streamQ[0]);
    sum = 8'd0;
    for (int i = 0; i < 2 * n; i++) sum = sum + streamQ[1 + i];
`ifdef PROG_LOADER_CSUM_EN
    expectOk = (streamQ[2 * n + 1] == sum);
`else
    expectOk = 1'b1;
`endif
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("busyTimeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("writeCount", 32'(addrQ.size()), 32'(n));
    for (int i = 0; i < n && i < addrQ.size(); i++) begin
      word = {streamQ[1 + 2 * i], streamQ[2 + 2 * i]};
      checkOutput("writeAddr", addrQ[i], 32'(i));
      checkOutput("writeData", dataQ[i], 32'(word));
    end
    checkOutput("doneCount", 32'(doneCount), expectOk ? 32'd1 : 32'd0);
    checkOutput("cpuResetAfter", 32'(cpuReset), expectOk ? 32'd0 : 32'd1);
`ifdef PROG_LOADER_CSUM_EN
    checkOutput("errAfter", 32'(err), expectOk ? 32'd0 : 32'd1);
`else
    checkOutput("errAfter", 32'(err), 32'd0);
`endif
    checkOutput("addrHold", 32'(busIf.mem_addr), 32'(n - 1));
    checkOutput("wdataHold", 32'(busIf.mem_wdata), 32'({streamQ[2 * n - 1], streamQ[2 * n]}));
    if (mode == 0 && expectOk) begin
`ifdef PROG_LOADER_CSUM_EN
      checkOutput("loadLatency", 32'(doneCycle - startCycle), 32'(3 * n + 2));
`else
      checkOutput("loadLatency", 32'(doneCycle - startCycle), 32'(3 * n + 1));
`endif
    end
  endtask

  task automatic runLoad(input int mode);
    streamLimit = streamQ.size();
    beginLoad();
    applyStimulus(mode);
    finishLoad(mode);
  endtask

  task automatic pushDirected(input logic [7:0] csum);
    streamQ.delete();
    streamQ.push_back(8'h02);
    streamQ.push_back(8'h12);
    streamQ.push_back(8'h00);
    streamQ.push_back(8'h34);
    streamQ.push_back(8'h56);
`ifdef PROG_LOADER_CSUM_EN
    streamQ.push_back(csum);
`else
    if (csum == 8'd0) streamQ.push_back(8'h00);
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    reset = 1'b1;
    startPulse = 1'b0;
    busIf.in_valid = 1'b0;
    busIf.in_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rstCpuReset", 32'(cpuReset), 32'd1);
    checkOutput("rstAddr", 32'(busIf.mem_addr), 32'd0);
    checkOutput("rstWdata", 32'(busIf.mem_wdata), 32'd0);
    reset = 1'b0;

    busIf.in_valid = 1'b1;
    busIf.in_data = 8'hA5;
    repeat (5) @(negedge clk);
    checkOutput("idleCpuReset", 32'(cpuReset), 32'd1);
    checkOutput("idleReady", 32'(busIf.in_ready), 32'd0);
    checkOutput("idleWe", 32'(busIf.mem_we), 32'd0);
    checkOutput("idleDone", 32'(done), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleErr", 32'(err), 32'd0);
    checkOutput("idleNoWrites", 32'(addrQ.size()), 32'd0);
    busIf.in_valid = 1'b0;

    // 0x12+0x00+0x34+0x56 = 0x9C
    pushDirected(8'h9C);
    if (streamQ.size() > 6) void'(streamQ.pop_back());
    runLoad(0);
    runLoad(1);

    makeStream(256, 1'b0);
    runLoad(0);

`ifdef PROG_LOADER_CSUM_EN
    streamQ.delete();
    streamQ.push_back(8'h01);
    streamQ.push_back(8'h10);
    streamQ.push_back(8'h20);
    streamQ.push_back(8'h30);
    runLoad(0);
    streamQ[3] = 8'h31;
    runLoad(0);
`endif

    for (int t = 0; t < 6; t++) begin
      makeStream(int'($urandom_range(1, 10)), ($urandom_range(0, 3) == 0));
      runLoad(int'($urandom_range(0, 2)));
    end

    // Abort after the high byte of word 1; word 0 must already be in memory.
    pushDirected(8'h9C);
    if (streamQ.size() > 6) void'(streamQ.pop_back());
    streamLimit = 4;
    beginLoad();
    applyStimulus(0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midRstWe", 32'(busIf.mem_we), 32'd0);
    checkOutput("midRstCpuReset", 32'(cpuReset), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstReady", 32'(busIf.in_ready), 32'd0);
    checkOutput("midRstWrites", 32'(addrQ.size()), 32'd1);
    if (addrQ.size() > 0) checkOutput("midRstWord0", dataQ[0], 32'h1200);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    makeStream(3, 1'b0);
    runLoad(0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side counterpart to the CPU's instruction fetch path.
- Receives a byte stream over a valid/ready handshake, packs bytes into 16-bit instruction words, and writes them into instruction memory from address 0 upward.
- Holds the CPU in reset while loading and releases it only after a successful load.
- Sits between an external byte source (host or UART receiver) and the instruction memory's write port.

Parameters:
- ADDR_W, 8, instruction memory address width (word-addressed).
- DATA_W, 16, instruction word width; must be 16, since two bytes make one word.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, single-cycle pulse that begins a load; honoured only in IDLE.
- in_valid, input, 1, source has a byte on in_data.
- in_data, input, 8, stream byte.
- in_ready, output, 1, loader accepts a byte this cycle.
- mem_we, output, 1, instruction memory write enable.
- mem_addr, output, ADDR_W, instruction memory write address.
- mem_wdata, output, DATA_W, instruction word to write.
- cpu_reset, output, 1, reset request to the CPU.
- busy, output, 1, a load is in progress.
- done, output, 1, one-cycle pulse on successful completion.
- err, output, 1, sticky error flag; cleared by reset or by the next start.

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, busy=0, done=0, err=0.
  - word counter=0, stored count=0, checksum accumulator=0.
- Byte transfer: happens only when in_valid=1 and in_ready=1 at a rising edge. in_data is ignored otherwise.
- Stream format:
  - COUNT byte N: 1..255 words, with N=0 meaning 256.
  - Then 2N data bytes, high byte first.
  - Then, if the optional feature is enabled, one checksum byte.
- FSM:
  - IDLE: in_ready=0. On start: go to COUNT; set busy=1, cpu_reset=1, err=0, word counter=0, checksum=0.
  - COUNT: in_ready=1. On transfer: store N, go to HI.
  - HI: in_ready=1. On transfer: latch mem_wdata[15:8], add byte to checksum, go to LO.
  - LO: in_ready=1. On transfer: latch mem_wdata[7:0], add byte to checksum, go to WRITE.
  - WRITE: in_ready=0, mem_we=1 for exactly one cycle, mem_addr=word counter.
    - Next cycle the counter increments.
    - If this was word N-1: go to CSUM (feature on) or FIN (feature off).
    - Otherwise go to HI.
  - FIN: done=1 for one cycle, busy=0, cpu_reset=0; go to IDLE.
- Throughput and latency:
  - Peak rate is one word per 3 cycles.
  - mem_we asserts the cycle after the LO byte transfer.
- mem_addr holds its last value outside WRITE.
- mem_wdata is stable throughout the mem_we cycle.
- Address arithmetic:
  - The word counter is ADDR_W+1 bits wide, so N=256 is reachable.
  - mem_addr is the counter's low ADDR_W bits; 256 words fill addresses 0..255 with no wrap beyond.
- The checksum is an 8-bit sum of all data bytes, mod 256; the COUNT byte is excluded.
- start while busy=1 is ignored.
- in_valid held with no start in IDLE: nothing is accepted.
- reset mid-load:
  - Returns to IDLE next edge with cpu_reset=1 and mem_we=0 in that same cycle.
  - Words already written remain in memory.
- cpu_reset stays 1 after reset until the first successful load. It re-asserts at every start.
- An accepted start with cpu_reset already 0 raises cpu_reset the next cycle.

Optional Feature:
- Macro: PROG_LOADER_CSUM_EN.
- When defined:
  - A CSUM state follows the final WRITE, with in_ready=1.
  - On transfer, the byte is compared with the accumulator.
  - Match: go to FIN.
  - Mismatch: err=1, busy=0, cpu_reset stays 1, no done pulse, go to IDLE.
- When undefined:
  - No CSUM state and no checksum byte is consumed.
  - err is tied to 0.
  - The final WRITE goes directly to FIN.

Test Plan:
- Reset, then idle 5 cycles -> cpu_reset=1, in_ready=0, mem_we=0, done=0, busy=0.
- start; stream 0x02,0x12,0x00,0x34,0x56 with in_valid held high (feature off) -> writes mem[0]=0x1200 and mem[1]=0x3456, one mem_we cycle each, done pulses once, cpu_reset falls to 0 with done.
- Same load with in_valid toggling 1/0 every cycle -> identical writes; no byte is duplicated or dropped; in_ready=0 during each WRITE cycle.
- COUNT byte 0x00 followed by 512 bytes -> 256 writes to addresses 0..255, last word at mem_addr=0xFF, then done.
- Feature on: stream 0x01,0x10,0x20, checksum 0x30 -> done, err=0. Repeat with checksum 0x31 -> err=1, no done, cpu_reset stays 1.
- reset asserted after the HI byte of word 1 -> next cycle IDLE, mem_we=0, cpu_reset=1. A following start reloads from address 0.
